// File: rtl/regfile_scanner.sv
// regfile_scanner
//   Walks a spare register-file read port from FIRST_REG to LAST_REG on a
//   start pulse, snapshots each register and streams it out over a
//   valid/ready handshake, tagged with its register index.
//
// Optional feature: define REGFILE_SCANNER_CHECKSUM_EN to append one extra
//   word per scan (out_index = 32, out_data = XOR of every word sent in that
//   scan). Without the macro there is no checksum state or register.
//
// Ports
//   clk         in   1   rising-edge clock
//   aclr        in   1   asynchronous active-high reset
//   start       in   1   scan request, honoured only while idle
//   busy        out  1   high whenever the engine is not idle
//   done        out  1   one-cycle pulse after the final word is accepted
//   rd_addr     out  5   registered read-select to the register file
//   rd_data     in  32   register file read data for rd_addr
//   out_valid   out  1   out_data/out_index hold a word
//   out_ready   in   1   consumer accepts the word
//   out_data    out 32   register snapshot or checksum word
//   out_index   out  6   register index 0..31, 32 marks the checksum word
//   dbg_state_o out  2   current FSM state encoding
//
// Handshake: a word transfers on every rising edge where out_valid and
//   out_ready are both high. Once raised, out_valid and the word stay
//   unchanged until that transfer happens; only aclr can drop them early.

module regfile_scanner #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_index,
  output logic [1:0]  dbg_state_o
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

`ifdef REGFILE_SCANNER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_SEND = 2'd2,
    S_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_SEND = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] out_data_q, out_data_d;
  logic [5:0]  out_index_q, out_index_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic hs;
  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= 5'd0;
      out_data_q  <= 32'd0;
      out_index_q <= 6'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
      csum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_addr_d = FIRST_ADDR;
`ifdef REGFILE_SCANNER_CHECKSUM_EN
          csum_d    = 32'd0;
`endif
          state_d   = S_ADDR;
        end
      end
      // rd_addr has been stable a full cycle, so rd_data is settled. A
      // register write on this same edge is not seen: the old value wins.
      S_ADDR: begin
        out_data_d  = rd_data;
        out_index_d = {1'b0, rd_addr_q};
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
`ifdef REGFILE_SCANNER_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (rd_addr_q != LAST_ADDR) begin
            rd_addr_d   = rd_addr_q + 5'd1;
            out_valid_d = 1'b0;
            state_d     = S_ADDR;
          end else begin
`ifdef REGFILE_SCANNER_CHECKSUM_EN
            // Present the finished checksum directly; valid stays high.
            out_data_d  = csum_q ^ out_data_q;
            out_index_d = 6'd32;
            state_d     = S_CSUM;
`else
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
`endif
          end
        end
      end
`ifdef REGFILE_SCANNER_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign rd_addr     = rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_scanner.sv
module tb_regfile_scanner;

`ifdef REGFILE_SCANNER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  // clock / reset
  logic clk;
  logic aclr;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // register file model shared by both scanners
  logic [31:0] regs [32];

  // instance a: default range 0..31
  logic        start_a, busy_a, done_a, valid_a, ready_a;
  logic [4:0]  addr_a;
  logic [31:0] rdat_a, data_a;
  logic [5:0]  idx_a;
  logic [1:0]  st_a;
  // instance b: single register 5
  logic        start_b, busy_b, done_b, valid_b, ready_b;
  logic [4:0]  addr_b;
  logic [31:0] rdat_b, data_b;
  logic [5:0]  idx_b;
  logic [1:0]  st_b;

  always_comb rdat_a = (addr_a == 5'd0) ? 32'd0 : regs[addr_a];
  always_comb rdat_b = (addr_b == 5'd0) ? 32'd0 : regs[addr_b];

  regfile_scanner u_a (
    .clk(clk), .aclr(aclr), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(addr_a), .rd_data(rdat_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_data(data_a), .out_index(idx_a),
    .dbg_state_o(st_a)
  );

  regfile_scanner #(.FIRST_REG(5), .LAST_REG(5)) u_b (
    .clk(clk), .aclr(aclr), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(addr_b), .rd_data(rdat_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_data(data_b), .out_index(idx_b),
    .dbg_state_o(st_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [37:0] exp_q[$];

  // drivers
  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
  endtask

  task automatic load_regs();
    regs[0] = 32'd0;
    for (int k = 1; k < 32; k++) regs[k] = 32'h1000_0000 + k;
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    #1;
    n_checks++;
    if ({busy_a, done_a, valid_a, addr_a, data_a, idx_a, st_a} !== 46'd0) begin
      $display("FAIL reset_a: got busy=%b done=%b valid=%b addr=%0d data=%h idx=%0d st=%0d want all 0",
               busy_a, done_a, valid_a, addr_a, data_a, idx_a, st_a);
    end else n_pass++;
    n_checks++;
    if ({busy_b, done_b, valid_b, addr_b, data_b, idx_b, st_b} !== 46'd0) begin
      $display("FAIL reset_b: got busy=%b done=%b valid=%b addr=%0d data=%h idx=%0d want all 0",
               busy_b, done_b, valid_b, addr_b, data_b, idx_b);
    end else n_pass++;
    repeat (2) @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [31:0] x;
    int done_at;
    x = 32'd0;
    load_regs();
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back({6'(k), regs[k]});
      x = x ^ regs[k];
    end
    if (CS == 1) exp_q.push_back({6'd32, x});
    ready_a = 1'b1;
    pulse_start_a();
    n_checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== 5'd0 || st_a !== 2'd1) begin
      $display("FAIL scan_addr_phase: got busy=%b valid=%b addr=%0d st=%0d want 1 0 0 1",
               busy_a, valid_a, addr_a, st_a);
    end else n_pass++;
    done_at = -1;
    for (int j = 1; j < 200 && done_at < 0; j++) begin
      @(negedge clk);
      if (done_a) begin
        done_at = j;
        n_checks++;
        if (busy_a !== 1'b0 || st_a !== 2'd0 || valid_a !== 1'b0) begin
          $display("FAIL scan_done_idle: got busy=%b st=%0d valid=%b want 0 0 0", busy_a, st_a, valid_a);
        end else n_pass++;
      end else if (valid_a) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scan_word: got extra word idx=%0d data=%h want none", idx_a, data_a);
        end else if ({idx_a, data_a} !== exp_q[0]) begin
          $display("FAIL scan_word: got idx=%0d data=%h want idx=%0d data=%h",
                   idx_a, data_a, exp_q[0][37:32], exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end else begin
          n_pass++;
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++;
    if (done_at !== 64 + CS) begin
      $display("FAIL scan_done_time: got %0d want %0d", done_at, 64 + CS);
    end else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scan_words_left: got %0d want 0", exp_q.size());
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic [5:0]  i0;
    int hs, dn;
    logic [31:0] csum_seen;
    regs[5] = 32'hDEAD_BEEF;
    ready_b = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_b !== 1'b1 || data_b !== 32'hDEAD_BEEF || idx_b !== 6'd5 || addr_b !== 5'd5) begin
      $display("FAIL bp_first: got valid=%b data=%h idx=%0d addr=%0d want 1 deadbeef 5 5",
               valid_b, data_b, idx_b, addr_b);
    end else n_pass++;
    d0 = data_b;
    i0 = idx_b;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_checks++;
      if (valid_b !== 1'b1 || data_b !== d0 || idx_b !== i0 || addr_b !== 5'd5) begin
        $display("FAIL bp_hold: got valid=%b data=%h idx=%0d addr=%0d want 1 %h %0d 5",
                 valid_b, data_b, idx_b, addr_b, d0, i0);
      end else n_pass++;
    end
    ready_b = 1'b1;
    hs = 0;
    dn = 0;
    csum_seen = 32'd0;
    for (int c = 0; c < 10; c++) begin
      if (valid_b && ready_b) begin
        hs++;
        if (idx_b == 6'd32) csum_seen = data_b;
      end
      if (done_b) dn++;
      @(negedge clk);
    end
    ready_b = 1'b0;
    n_checks++;
    if (hs != 1 + CS) begin
      $display("FAIL bp_handshakes: got %0d want %0d", hs, 1 + CS);
    end else n_pass++;
    n_checks++;
    if (dn != 1) begin
      $display("FAIL bp_done_pulses: got %0d want 1", dn);
    end else n_pass++;
    if (CS == 1) begin
      n_checks++;
      if (csum_seen !== 32'hDEAD_BEEF) begin
        $display("FAIL bp_csum: got %h want deadbeef", csum_seen);
      end else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    bit found, seen;
    regs[3] = 32'hAAAA_AAAA;
    ready_a = 1'b1;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (valid_a && idx_a == 6'd3) found = 1'b1;
    end
    ready_a = 1'b0;
    regs[3] = 32'h5555_5555;
    repeat (2) @(negedge clk);
    n_checks++;
    if (!found || valid_a !== 1'b1 || idx_a !== 6'd3 || data_a !== 32'hAAAA_AAAA) begin
      $display("FAIL snap_hold: got found=%b valid=%b idx=%0d data=%h want 1 1 3 aaaaaaaa",
               found, valid_a, idx_a, data_a);
    end else n_pass++;
    ready_a = 1'b1;
    wait_done_a(200, seen);
    n_checks++;
    if (!seen) $display("FAIL snap_done1: got no done want done");
    else n_pass++;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (valid_a && idx_a == 6'd3) found = 1'b1;
    end
    n_checks++;
    if (!found || data_a !== 32'h5555_5555) begin
      $display("FAIL snap_rescan: got found=%b data=%h want 1 55555555", found, data_a);
    end else n_pass++;
    wait_done_a(200, seen);
    n_checks++;
    if (!seen) $display("FAIL snap_done2: got no done want done");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int words, done_at;
    bit seen;
    ready_a = 1'b1;
    pulse_start_a();
    words = 0;
    done_at = -1;
    for (int j = 1; j < 200 && done_at < 0; j++) begin
      @(negedge clk);
      if (done_a) done_at = j;
      else if (valid_a) words++;
      start_a = (j == 10) || (done_at >= 0);
    end
    n_checks++;
    if (words != 32 + CS || done_at != 64 + CS) begin
      $display("FAIL busy_start_ignored: got words=%0d done_at=%0d want %0d %0d",
               words, done_at, 32 + CS, 64 + CS);
    end else n_pass++;
    // start was raised in the done cycle
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1 || valid_a !== 1'b0 || addr_a !== 5'd0) begin
      $display("FAIL b2b_accept: got busy=%b valid=%b addr=%0d want 1 0 0", busy_a, valid_a, addr_a);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (valid_a !== 1'b1 || idx_a !== 6'd0 || data_a !== 32'd0) begin
      $display("FAIL b2b_first: got valid=%b idx=%0d data=%h want 1 0 0", valid_a, idx_a, data_a);
    end else n_pass++;
    wait_done_a(200, seen);
    n_checks++;
    if (!seen) $display("FAIL b2b_done: got no done want done");
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    int dn, done_at;
    logic [31:0] x;
    ready_a = 1'b1;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (valid_a && idx_a == 6'd12) found = 1'b1;
    end
    ready_a = 1'b0;
    #2 aclr = 1'b1;
    #1;
    n_checks++;
    if (!found || {busy_a, done_a, valid_a, addr_a, data_a, idx_a, st_a} !== 46'd0) begin
      $display("FAIL rst_mid: got found=%b busy=%b done=%b valid=%b addr=%0d data=%h idx=%0d want 1 and all 0",
               found, busy_a, done_a, valid_a, addr_a, data_a, idx_a);
    end else n_pass++;
    @(negedge clk);
    aclr = 1'b0;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_a || valid_a || busy_a) dn++;
    end
    n_checks++;
    if (dn != 0) $display("FAIL rst_quiet: got %0d active cycles want 0", dn);
    else n_pass++;
    // rescan from FIRST_REG with a fresh checksum
    exp_q.delete();
    x = 32'd0;
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back({6'(k), regs[k]});
      x = x ^ regs[k];
    end
    if (CS == 1) exp_q.push_back({6'd32, x});
    ready_a = 1'b1;
    pulse_start_a();
    done_at = -1;
    dn = 0;
    for (int j = 1; j < 200 && done_at < 0; j++) begin
      @(negedge clk);
      if (done_a) done_at = j;
      else if (valid_a) begin
        if (exp_q.size() == 0 || {idx_a, data_a} !== exp_q[0]) dn++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (dn != 0 || exp_q.size() != 0 || done_at != 64 + CS) begin
      $display("FAIL rst_rescan: got bad_words=%0d left=%0d done_at=%0d want 0 0 %0d",
               dn, exp_q.size(), done_at, 64 + CS);
    end else n_pass++;
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    aclr    = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'd0;
    test_reset();
    test_full_scan();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
